// File: rtl/mcs8_pkg.sv
// mcs8_pkg
// Shared constants and types for the MCS-8 program-counter front end.
//   ADDR_W   : program-address width
//   DEPTH    : address-stack entries (current PC plus return levels)
//   KILL_LEN : number of fetch stages squashed after a redirect
//   pcState_e: sequencer states (RUN, FLUSH, HALT)
package mcs8_pkg;

  localparam int ADDR_W   = 14;
  localparam int DEPTH    = 8;
  localparam int KILL_LEN = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } pcState_e;

endpackage

// File: rtl/pc_stack_rf.sv
// pc_stack_rf
// Address-stack storage: DEPTH entries of ADDR_W bits.
// Ports:
//   CLK_I, RST_I      : clock and synchronous active-high reset (clears all entries)
//   rdAddr / rdData   : asynchronous read port
//   weA, waA, wdA     : synchronous write port A
//   weB, waB, wdB     : synchronous write port B (wins when both ports hit one entry)
module pc_stack_rf #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [AW-1:0]     rdAddr,
  output logic [ADDR_W-1:0] rdData,
  input  logic              weA,
  input  logic [AW-1:0]     waA,
  input  logic [ADDR_W-1:0] wdA,
  input  logic              weB,
  input  logic [AW-1:0]     waB,
  input  logic [ADDR_W-1:0] wdB
);

  logic [ADDR_W-1:0] mem [DEPTH];

  assign rdData = mem[rdAddr];

  // Port B is written after port A so it takes precedence on an address clash.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (weA) begin
        mem[waA] <= wdA;
      end
      if (weB) begin
        mem[waB] <= wdB;
      end
    end
  end

endmodule

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl
// Program-counter sequencer built around a circular return-address stack.
// The current fetch address is always stack[SP]. Events are prioritised
// INT > RET > CALL > JMP > HLT > increment; every redirect squashes the
// following KILL_LEN fetch stages.
// Ports:
//   CLK_I, RST_I            : clock, synchronous active-high reset
//   STALL_I                 : hold the PC instead of incrementing
//   JMP_I, CALL_I, RET_I    : control-flow events from execute
//   HLT_I, INT_I, VEC_I     : halt request, interrupt and its vector number
//   TGT_I, RETA_I           : jump/call target and return address
//   I_ADDR_O                : fetch address
//   KILL_O                  : squash fetch-pipe valid bits
//   SP_O                    : stack pointer
//   HALT_O                  : high while halted
//   OVF_O, UNF_O            : sticky stack overflow / underflow
module pc_stack_ctrl
  import mcs8_pkg::*;
#(
  parameter int ADDR_W   = mcs8_pkg::ADDR_W,
  parameter int DEPTH    = mcs8_pkg::DEPTH,
  parameter int KILL_LEN = mcs8_pkg::KILL_LEN
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STALL_I,
  input  logic              JMP_I,
  input  logic              CALL_I,
  input  logic              RET_I,
  input  logic              HLT_I,
  input  logic              INT_I,
  input  logic [2:0]        VEC_I,
  input  logic [ADDR_W-1:0] TGT_I,
  input  logic [ADDR_W-1:0] RETA_I,
  output logic [ADDR_W-1:0] I_ADDR_O,
  output logic              KILL_O,
  output logic [2:0]        SP_O,
  output logic              HALT_O,
  output logic              OVF_O,
  output logic              UNF_O
);

  localparam int CNT_W = (KILL_LEN < 1) ? 1 : $clog2(KILL_LEN + 1);

  pcState_e          state, nextState;
  logic [CNT_W-1:0]  cnt, nextCnt;
  logic [2:0]        sp, nextSp, spInc, spDec;
  logic              ovf, unf, setOvf, setUnf;
  logic [ADDR_W-1:0] curPc, intTgt, pushTgt;
  logic              doPush, redirect;
  logic              weA, weB;
  logic [2:0]        waA, waB;
  logic [ADDR_W-1:0] wdA, wdB;

  pc_stack_rf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .AW     (3)
  ) stackRf (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .rdAddr (sp),
    .rdData (curPc),
    .weA    (weA),
    .waA    (waA),
    .wdA    (wdA),
    .weB    (weB),
    .waB    (waB),
    .wdB    (wdB)
  );

  // The pointer wraps modulo DEPTH, which need not be a power of two.
  assign spInc  = (sp == 3'(DEPTH - 1)) ? 3'd0 : sp + 3'd1;
  assign spDec  = (sp == 3'd0) ? 3'(DEPTH - 1) : sp - 3'd1;
  assign intTgt = {{(ADDR_W - 6){1'b0}}, VEC_I, 3'b000};

  // Event decode, stack write ports and next-state. A push saves the return
  // address into the current entry (port A) and the target into the new top
  // (port B) in the same cycle.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextSp    = sp;
    weA       = 1'b0;
    waA       = sp;
    wdA       = curPc + ADDR_W'(1);
    weB       = 1'b0;
    waB       = spInc;
    wdB       = TGT_I;
    setOvf    = 1'b0;
    setUnf    = 1'b0;
    doPush    = 1'b0;
    pushTgt   = TGT_I;
    redirect  = 1'b0;

    if (state == HALT) begin
      if (INT_I) begin
        doPush  = 1'b1;
        pushTgt = intTgt;
      end
    end else begin
      if (INT_I) begin
        doPush  = 1'b1;
        pushTgt = intTgt;
      end else if (RET_I) begin
        nextSp   = spDec;
        setUnf   = (sp == 3'd0);
        redirect = 1'b1;
      end else if (CALL_I) begin
        doPush = 1'b1;
      end else if (JMP_I) begin
        weA      = 1'b1;
        wdA      = TGT_I;
        redirect = 1'b1;
      end else if (HLT_I) begin
        nextState = HALT;
        nextCnt   = '0;
      end else if (!STALL_I) begin
        weA = 1'b1;
      end
    end

    if (doPush) begin
      weA      = 1'b1;
      wdA      = RETA_I;
      weB      = 1'b1;
      wdB      = pushTgt;
      nextSp   = spInc;
      setOvf   = (sp == 3'(DEPTH - 1));
      redirect = 1'b1;
    end

    // A redirect (re)starts the squash window; otherwise FLUSH counts down.
    if (redirect) begin
      nextState = (KILL_LEN > 0) ? FLUSH : RUN;
      nextCnt   = CNT_W'(KILL_LEN);
    end else if (state == FLUSH && nextState == FLUSH) begin
      nextCnt = cnt - CNT_W'(1);
      if (cnt <= CNT_W'(1)) begin
        nextState = RUN;
      end
    end
  end

  // Sequencer registers; the overflow/underflow flags only ever accumulate.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= RUN;
      cnt   <= '0;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      sp    <= nextSp;
      ovf   <= ovf | setOvf;
      unf   <= unf | setUnf;
    end
  end

  assign I_ADDR_O = curPc;
  assign KILL_O   = (state == FLUSH);
  assign HALT_O   = (state == HALT);
  assign SP_O     = sp;
  assign OVF_O    = ovf;
  assign UNF_O    = unf;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb_pc_stack_ctrl
// Self-checking bench for pc_stack_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the address stack.
module tb_pc_stack_ctrl;

  localparam int AW    = 14;
  localparam int DEP   = 8;
  localparam int KLEN  = 3;
  localparam int AMASK = (1 << AW) - 1;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        STALL_I = 1'b0;
  logic        JMP_I = 1'b0;
  logic        CALL_I = 1'b0;
  logic        RET_I = 1'b0;
  logic        HLT_I = 1'b0;
  logic        INT_I = 1'b0;
  logic [2:0]  VEC_I = '0;
  logic [13:0] TGT_I = '0;
  logic [13:0] RETA_I = '0;
  logic [13:0] I_ADDR_O;
  logic        KILL_O;
  logic [2:0]  SP_O;
  logic        HALT_O;
  logic        OVF_O;
  logic        UNF_O;

  always #5 CLK_I = ~CLK_I;

  pc_stack_ctrl dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .STALL_I  (STALL_I),
    .JMP_I    (JMP_I),
    .CALL_I   (CALL_I),
    .RET_I    (RET_I),
    .HLT_I    (HLT_I),
    .INT_I    (INT_I),
    .VEC_I    (VEC_I),
    .TGT_I    (TGT_I),
    .RETA_I   (RETA_I),
    .I_ADDR_O (I_ADDR_O),
    .KILL_O   (KILL_O),
    .SP_O     (SP_O),
    .HALT_O   (HALT_O),
    .OVF_O    (OVF_O),
    .UNF_O    (UNF_O)
  );

  // Behavioural model: a plain array of addresses, a pointer, and a count
  // of remaining squash cycles.
  int mStk [DEP];
  int mSp;
  int mKill;
  bit mHalt;
  bit mOvf;
  bit mUnf;
  bit checkEn = 1'b0;

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic modelPush(input int tgt, input int reta);
    if (mSp == DEP - 1) mOvf = 1'b1;
    mStk[mSp] = reta & AMASK;
    mSp = (mSp + 1) % DEP;
    mStk[mSp] = tgt & AMASK;
    mKill = KLEN;
  endtask

  task automatic modelStep(input bit rst, input bit stall, input bit jmp, input bit call,
                           input bit ret, input bit hlt, input bit intr, input int vec,
                           input int tgt, input int reta);
    if (rst) begin
      foreach (mStk[i]) mStk[i] = 0;
      mSp = 0; mKill = 0; mHalt = 1'b0; mOvf = 1'b0; mUnf = 1'b0;
    end else if (mHalt) begin
      if (intr) begin
        modelPush(vec * 8, reta);
        mHalt = 1'b0;
      end
    end else if (intr) begin
      modelPush(vec * 8, reta);
    end else if (ret) begin
      if (mSp == 0) mUnf = 1'b1;
      mSp = (mSp + DEP - 1) % DEP;
      mKill = KLEN;
    end else if (call) begin
      modelPush(tgt, reta);
    end else if (jmp) begin
      mStk[mSp] = tgt & AMASK;
      mKill = KLEN;
    end else if (hlt) begin
      mHalt = 1'b1;
      mKill = 0;
    end else begin
      if (!stall) mStk[mSp] = (mStk[mSp] + 1) & AMASK;
      if (mKill > 0) mKill--;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic applyStimulus(input bit rst, input bit stall, input bit jmp, input bit call,
                               input bit ret, input bit hlt, input bit intr, input int vec,
                               input int tgt, input int reta);
    RST_I = rst; STALL_I = stall; JMP_I = jmp; CALL_I = call; RET_I = ret;
    HLT_I = hlt; INT_I = intr; VEC_I = 3'(vec); TGT_I = 14'(tgt); RETA_I = 14'(reta);
    @(posedge CLK_I);
    modelStep(rst, stall, jmp, call, ret, hlt, intr, vec, tgt, reta);
    #1;
    RST_I = 1'b0; STALL_I = 1'b0; JMP_I = 1'b0; CALL_I = 1'b0; RET_I = 1'b0;
    HLT_I = 1'b0; INT_I = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge CLK_I) begin
    if (checkEn) begin
      checkOutput("model addr", int'(I_ADDR_O), mStk[mSp]);
      checkOutput("model kill", int'(KILL_O), int'(mKill > 0));
      checkOutput("model sp",   int'(SP_O), mSp);
      checkOutput("model halt", int'(HALT_O), int'(mHalt));
      checkOutput("model ovf",  int'(OVF_O), int'(mOvf));
      checkOutput("model unf",  int'(UNF_O), int'(mUnf));
    end
  end

  initial begin
    doReset();
    checkEn = 1'b1;

    // Reset then idle counting.
    checkOutput("reset addr", int'(I_ADDR_O), 0);
    checkOutput("reset kill", int'(KILL_O), 0);
    checkOutput("reset halt", int'(HALT_O), 0);
    for (int i = 1; i < 5; i++) begin
      idle();
      checkOutput("idle addr", int'(I_ADDR_O), i);
      checkOutput("idle kill", int'(KILL_O), 0);
    end

    // Jump and the squash window.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 'h1234, 0);
    checkOutput("jmp addr", int'(I_ADDR_O), 'h1234);
    checkOutput("jmp kill n+1", int'(KILL_O), 1);
    idle();
    checkOutput("jmp kill n+2", int'(KILL_O), 1);
    idle();
    checkOutput("jmp kill n+3", int'(KILL_O), 1);
    checkOutput("jmp addr n+3", int'(I_ADDR_O), 'h1236);
    idle();
    checkOutput("jmp kill n+4", int'(KILL_O), 0);

    // Call then return.
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 'h0200, 'h0013);
    checkOutput("call sp", int'(SP_O), 1);
    checkOutput("call addr", int'(I_ADDR_O), 'h0200);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("ret sp", int'(SP_O), 0);
    checkOutput("ret addr", int'(I_ADDR_O), 'h0013);

    // Eight nested calls wrap the pointer, then an underflowing return.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 'h100 + i, i);
    end
    checkOutput("nest sp", int'(SP_O), 0);
    checkOutput("nest ovf", int'(OVF_O), 1);
    checkOutput("nest unf", int'(UNF_O), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("wrap ret sp", int'(SP_O), 7);
    checkOutput("wrap ret unf", int'(UNF_O), 1);
    checkOutput("wrap ret addr", int'(I_ADDR_O), 7);

    // Halt, ignored jump, interrupt exit.
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("hlt halt", int'(HALT_O), 1);
    checkOutput("hlt addr", int'(I_ADDR_O), 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 'h0100, 0);
    checkOutput("hlt jmp addr", int'(I_ADDR_O), 0);
    checkOutput("hlt jmp halt", int'(HALT_O), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 'h0055);
    checkOutput("int addr", int'(I_ADDR_O), 'h0028);
    checkOutput("int halt", int'(HALT_O), 0);
    checkOutput("int kill", int'(KILL_O), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("int saved reta", int'(I_ADDR_O), 'h0055);

    // Simultaneous call and return; stall with jump.
    doReset();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 'h0300, 'h0001);
    checkOutput("call+ret sp", int'(SP_O), 7);
    checkOutput("call+ret unf", int'(UNF_O), 1);
    checkOutput("call+ret ovf", int'(OVF_O), 0);
    doReset();
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 'h0777, 0);
    checkOutput("stall jmp addr", int'(I_ADDR_O), 'h0777);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall hold addr", int'(I_ADDR_O), 'h0777);

    // Randomized traffic, with occasional reset mid-flight.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 11) == 0,
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, AMASK)),
                    int'($urandom_range(0, AMASK)));
    end

    @(negedge CLK_I);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
